// File: rtl/axi_stream_slave_if.sv
// +----------------------------------------------------------------------+
// | Module : axi_if                                                      |
// | Brief  : 8-bit AXI-Stream bundle with master/slave views             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface axi_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/axi_stream_slave.sv
// +----------------------------------------------------------------------+
// | Module : axi_stream_slave                                            |
// | Brief  : ID-filtered AXI-Stream packet assembler with error counters |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module axi_stream_slave #(
  parameter int         PCK_SIZE = 4,
  parameter logic [7:0] ID_VALID = 8'h7F
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_if.slave                    axi,
  output logic [8*PCK_SIZE-1:0]   pkt_data,
  output logic                    pkt_valid,
  output logic                    len_err,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int                IDX_W      = (PCK_SIZE > 1) ? $clog2(PCK_SIZE) : 1;
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(PCK_SIZE - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RECV = 2'd1;
  localparam logic [1:0] c_DROP = 2'd2;

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [8*PCK_SIZE-1:0]   r_buf;
  logic [8*PCK_SIZE-1:0]   r_pkt_data;
  logic                    r_tready;
  logic                    r_pkt_valid;
  logic                    r_len_err;
  logic [15:0]             r_pkt_cnt;
  logic [15:0]             r_drop_cnt;

  logic                    w_xfer;
  logic                    w_last_idx;
  logic [8*PCK_SIZE-1:0]   w_asm;

  assign w_xfer     = axi.tvalid & r_tready;
  assign w_last_idx = (r_idx == c_LAST_IDX);

  // Buffer with the current beat merged in, so the final byte is usable on its own edge
  always_comb begin
    w_asm = r_buf;
    for (int i = 0; i < PCK_SIZE; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_asm[8*(PCK_SIZE-1-i) +: 8] = axi.tdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_idx       <= '0;
      r_buf       <= '0;
      r_pkt_data  <= '0;
      r_tready    <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_len_err   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_tready    <= 1'b1;
      r_pkt_valid <= 1'b0;
      r_len_err   <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          c_IDLE: begin
            r_idx <= '0;
            if (axi.tlast) begin
              r_len_err <= 1'b1;
            end else if (axi.tdata == ID_VALID) begin
              r_state <= c_RECV;
            end else begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
              r_state    <= c_DROP;
            end
          end
          c_RECV: begin
            r_buf <= w_asm;
            if (axi.tlast) begin
              r_state <= c_IDLE;
              r_idx   <= '0;
              if (w_last_idx) begin
                r_pkt_data  <= w_asm;
                r_pkt_valid <= 1'b1;
                r_pkt_cnt   <= r_pkt_cnt + 16'd1;
              end else begin
                r_len_err <= 1'b1;
              end
            end else if (w_last_idx) begin
              // Payload full but no tlast: flush the remainder of the packet
              r_len_err <= 1'b1;
              r_state   <= c_DROP;
              r_idx     <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          c_DROP: begin
            if (axi.tlast) begin
              r_state <= c_IDLE;
            end
          end
          default: begin
            r_state <= c_IDLE;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

  assign axi.tready = r_tready;
  assign pkt_data   = r_pkt_data;
  assign pkt_valid  = r_pkt_valid;
  assign len_err    = r_len_err;
  assign pkt_cnt    = r_pkt_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_slave.sv
// +----------------------------------------------------------------------+
// | Module : tb_axi_stream_slave                                         |
// | Brief  : vector table, corner sequences and randomized packet stream |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_axi_stream_slave;

  localparam int         P  = 4;
  localparam logic [7:0] ID = 8'h7F;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    int          gap;
    logic        epv;
    logic        ele;
    logic [31:0] epd;
    logic [15:0] epc;
    logic [15:0] edc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        len_err;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  axi_if axi ();

  axi_stream_slave #(.PCK_SIZE(P), .ID_VALID(ID)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi.slave),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .len_err   (len_err),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: collects each packet's beats and judges them by the packet rules
  logic [7:0]  q[$];
  logic        m_ready = 1'b0;
  logic        m_pv, m_le;
  logic [31:0] m_pdata = '0;
  logic [15:0] m_pcnt = '0;
  logic [15:0] m_drop = '0;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("tready",    64'(axi.tready), 64'(m_ready));
    chk("pkt_valid", 64'(pkt_valid),  64'(m_pv));
    chk("len_err",   64'(len_err),    64'(m_le));
    chk("pkt_data",  64'(pkt_data),   64'(m_pdata));
    chk("pkt_cnt",   64'(pkt_cnt),    64'(m_pcnt));
    chk("drop_cnt",  64'(drop_cnt),   64'(m_drop));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l);
    logic [31:0] acc;
    rst = 1'b0;
    axi.tvalid = v;
    axi.tdata  = d;
    axi.tlast  = l;
    @(posedge clk);
    #1;
    m_pv = 1'b0;
    m_le = 1'b0;
    if (v && m_ready) begin
      q.push_back(d);
      if (q.size() == 1) begin
        if (l) m_le = 1'b1;
        else if (d != ID) m_drop++;
      end else if (q[0] == ID) begin
        if (l && q.size() == P + 1) begin
          acc = '0;
          for (int i = 1; i <= P; i++) acc = (acc << 8) | 32'(q[i]);
          m_pdata = acc;
          m_pv    = 1'b1;
          m_pcnt++;
        end else if (q.size() <= P && l) begin
          m_le = 1'b1;
        end else if (q.size() == P + 1 && !l) begin
          m_le = 1'b1;
        end
      end
      if (l) q.delete();
    end
    m_ready = 1'b1;
    check_model();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      axi.tvalid = 1'($urandom);
      axi.tdata  = 8'($urandom);
      axi.tlast  = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_tready",   64'(axi.tready), 64'd0);
      chk("rst_outputs",  {pkt_data, 16'(pkt_cnt ^ drop_cnt), 14'd0, pkt_valid, len_err}, 64'd0);
    end
    q.delete();
    m_ready = 1'b0;
    m_pdata = '0;
    m_pcnt  = '0;
    m_drop  = '0;
    m_pv    = 1'b0;
    m_le    = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input int gap,
                     input logic epv, input logic ele, input logic [31:0] epd,
                     input logic [15:0] epc, input logic [15:0] edc);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.gap = gap;
    t.epv = epv; t.ele = ele; t.epd = epd; t.epc = epc; t.edc = edc;
    tbl.push_back(t);
  endtask

  initial begin
    axi.tvalid = 1'b0;
    axi.tdata  = '0;
    axi.tlast  = 1'b0;

    // Good packet, two gapped packets, bad ID, short, long, ID-with-tlast, back-to-back
    add(1, 8'h7F, 0, 0, 0, 0, 32'h0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 32'h0, 0, 0);
    add(1, 8'hBB, 0, 0, 0, 0, 32'h0, 0, 0);
    add(1, 8'hCC, 0, 0, 0, 0, 32'h0, 0, 0);
    add(1, 8'hDD, 1, 2, 1, 0, 32'hAABBCCDD, 1, 0);
    add(1, 8'h7F, 0, 0, 0, 0, 32'hAABBCCDD, 1, 0);
    add(1, 8'h45, 0, 0, 0, 0, 32'hAABBCCDD, 1, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 32'hAABBCCDD, 1, 0);
    add(1, 8'h12, 0, 0, 0, 0, 32'hAABBCCDD, 1, 0);
    add(1, 8'h34, 1, 10, 1, 0, 32'h45AA1234, 2, 0);
    add(1, 8'h7F, 0, 0, 0, 0, 32'h45AA1234, 2, 0);
    add(1, 8'h43, 0, 0, 0, 0, 32'h45AA1234, 2, 0);
    add(1, 8'h21, 0, 0, 0, 0, 32'h45AA1234, 2, 0);
    add(1, 8'h44, 0, 0, 0, 0, 32'h45AA1234, 2, 0);
    add(1, 8'h55, 1, 1, 1, 0, 32'h43214455, 3, 0);
    add(1, 8'h00, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h11, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h22, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h33, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h44, 1, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h7F, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h01, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h02, 1, 0, 0, 1, 32'h43214455, 3, 1);
    add(1, 8'h7F, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h01, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h02, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h03, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h04, 0, 0, 0, 1, 32'h43214455, 3, 1);
    add(1, 8'h05, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h06, 1, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'h7F, 1, 0, 0, 1, 32'h43214455, 3, 1);
    add(1, 8'h7F, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'hA1, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'hB2, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(0, 8'h55, 1, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'hC3, 0, 0, 0, 0, 32'h43214455, 3, 1);
    add(1, 8'hD4, 1, 0, 1, 0, 32'hA1B2C3D4, 4, 1);
    add(1, 8'h00, 0, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h99, 1, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h7F, 0, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h01, 0, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h02, 0, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h03, 0, 0, 0, 0, 32'hA1B2C3D4, 4, 2);
    add(1, 8'h04, 1, 0, 1, 0, 32'h01020304, 5, 2);

    do_reset(10);
    step(1'b0, 8'h00, 1'b0);

    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].d, tbl[k].l);
      chk("vec_pkt_valid", 64'(pkt_valid), 64'(tbl[k].epv));
      chk("vec_len_err",   64'(len_err),   64'(tbl[k].ele));
      chk("vec_pkt_data",  64'(pkt_data),  64'(tbl[k].epd));
      chk("vec_pkt_cnt",   64'(pkt_cnt),   64'(tbl[k].epc));
      chk("vec_drop_cnt",  64'(drop_cnt),  64'(tbl[k].edc));
      for (int g = 0; g < tbl[k].gap; g++) begin
        step(1'b0, 8'(g), 1'b0);
        chk("gap_hold", {pkt_data, 16'(pkt_cnt), 15'd0, pkt_valid},
            {tbl[k].epd, tbl[k].epc, 16'd0});
      end
    end

    // Reset mid-packet abandons it; next beat after release is an ID
    step(1'b1, 8'h7F, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    do_reset(3);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h7F, 1'b0);
    step(1'b1, 8'h09, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    step(1'b1, 8'h06, 1'b1);
    chk("post_rst_pkt", {pkt_data, pkt_cnt, drop_cnt}, {32'h09080706, 16'd1, 16'd0});

    // Random packet stream with idle gaps and occasional mid-packet reset
    for (int k = 0; k < 400; k++) begin
      logic [7:0] id;
      int         len;
      bool_reset: begin end
      id  = ($urandom_range(0, 9) < 7) ? ID : 8'($urandom);
      len = $urandom_range(0, P + 3);
      for (int b = 0; b <= len; b++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'($urandom));
        step(1'b1, (b == 0) ? id : 8'($urandom), (b == len) ? 1'b1 : 1'b0);
        if (b < len && $urandom_range(0, 99) == 0) begin
          do_reset(2);
          break;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
